// File: rtl/tsal_pkg.sv
// Shared types and parameter defaults for the tractive-system active light controller.
// State encoding is fixed because it is exported on the state output.
package tsal_pkg;
  typedef enum logic [1:0] {
    LAMP_TEST = 2'd0,
    SAFE      = 2'd1,
    ACTIVE    = 2'd2,
    FAULT     = 2'd3
  } tsal_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4000;
  localparam int IMPL_CYCLES_DEF     = 400000;
  localparam int TEST_CYCLES_DEF     = 4000000;
endpackage

// File: rtl/tsal_if.sv
// Sensor inputs and lamp/status outputs of the TSAL controller.
// master drives the sensors and observes the lamps; slave is the controller.
interface tsal_if;
  logic       hv_present;
  logic       air_p_closed;
  logic       air_n_closed;
  logic       fault_clr;
  logic       red_ctrl;
  logic       green_ctrl;
  logic       fault;
  logic [1:0] state;

  modport master (
    output hv_present, air_p_closed, air_n_closed, fault_clr,
    input  red_ctrl, green_ctrl, fault, state
  );

  modport slave (
    input  hv_present, air_p_closed, air_n_closed, fault_clr,
    output red_ctrl, green_ctrl, fault, state
  );
endinterface

// File: rtl/tsal_debounce.sv
// 2-FF synchronizer followed by a debouncer; output follows the synchronized value
// after DEBOUNCE_CYCLES consecutive differing samples (input edge -> output: DEBOUNCE_CYCLES+2 cycles).
module tsal_debounce
  import tsal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any sample agreeing with the output restarts the stability window.
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/tsal_controller.sv
// TSAL state machine: lamp test, safe/active indication and latched AIR/HV implausibility fault.
// Outputs are registered from next-state, so they change on the same edge as state.
module tsal_controller
  import tsal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int IMPL_CYCLES     = IMPL_CYCLES_DEF,
  parameter int TEST_CYCLES     = TEST_CYCLES_DEF
) (
  input logic   clk,
  input logic   rst,
  tsal_if.slave bus
);
  localparam int ICW = $clog2(IMPL_CYCLES + 1);
  localparam int TCW = $clog2(TEST_CYCLES + 1);
  localparam logic [ICW-1:0] IMPL_MAX = ICW'(IMPL_CYCLES);
  localparam logic [TCW-1:0] TEST_MAX = TCW'(TEST_CYCLES);

  localparam logic [1:0] ST_LAMP   = LAMP_TEST;
  localparam logic [1:0] ST_SAFE   = SAFE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_FAULT  = FAULT;

  logic           hv_db;
  logic           airp_db;
  logic           airn_db;
  logic           implausible;
  logic           impl_hold;
  logic [ICW-1:0] impl_cnt;
  logic [TCW-1:0] test_cnt;
  logic [1:0]     state_q;
  logic [1:0]     state_d;
  logic           red_q;
  logic           green_q;
  logic           fault_q;

  tsal_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hv (
    .clk(clk), .rst(rst), .din(bus.hv_present), .dout(hv_db)
  );
  tsal_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_airp (
    .clk(clk), .rst(rst), .din(bus.air_p_closed), .dout(airp_db)
  );
  tsal_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_airn (
    .clk(clk), .rst(rst), .din(bus.air_n_closed), .dout(airn_db)
  );

  // HV without any closed AIR, or both AIRs closed without HV.
  assign implausible = (hv_db & ~airp_db & ~airn_db) | (~hv_db & airp_db & airn_db);
  assign impl_hold   = (impl_cnt == IMPL_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LAMP: begin
        if (test_cnt == TEST_MAX) state_d = ST_SAFE;
      end
      ST_SAFE: begin
        if (impl_hold)                      state_d = ST_FAULT;
        else if (hv_db & (airp_db | airn_db)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (impl_hold)                        state_d = ST_FAULT;
        else if (~hv_db & ~airp_db & ~airn_db) state_d = ST_SAFE;
      end
      ST_FAULT: begin
        // A clear request is only honoured in the cycle it is seen while safe.
        if (bus.fault_clr & ~implausible & ~hv_db & ~impl_hold) state_d = ST_SAFE;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LAMP;
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      fault_q  <= 1'b0;
      test_cnt <= '0;
      impl_cnt <= '0;
    end else begin
      state_q <= state_d;
      red_q   <= (state_d == ST_LAMP) || (state_d == ST_ACTIVE);
      green_q <= (state_d == ST_LAMP) || (state_d == ST_SAFE);
      fault_q <= (state_d == ST_FAULT);

      if ((state_q == ST_LAMP) && (test_cnt != TEST_MAX)) test_cnt <= test_cnt + TCW'(1);

      if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) impl_cnt <= '0;
      else if (!implausible)                              impl_cnt <= '0;
      else if (!impl_hold)                                impl_cnt <= impl_cnt + ICW'(1);
    end
  end

  assign bus.state      = state_q;
  assign bus.red_ctrl   = red_q;
  assign bus.green_ctrl = green_q;
  assign bus.fault      = fault_q;
endmodule

// File: tb/tb_tsal_controller.sv
// Scoreboard bench for tsal_controller with short parameters; a reference model predicts
// the outputs after every clock edge and a monitor compares them against the DUT.
module tb_tsal_controller;
  localparam int DB   = 4;
  localparam int IMPL = 20;
  localparam int TEST = 10;
  localparam int MAXC = 8192;

  localparam logic [1:0] S_LAMP   = 2'd0;
  localparam logic [1:0] S_SAFE   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tsal_if bus ();

  tsal_controller #(
    .DEBOUNCE_CYCLES(DB),
    .IMPL_CYCLES(IMPL),
    .TEST_CYCLES(TEST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       red;
    logic       green;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: raw input history per edge since reset, debounced view and FSM state.
  logic       raw_hv[MAXC];
  logic       raw_p[MAXC];
  logic       raw_n[MAXC];
  logic       imp_h[MAXC];
  int         edge_n;
  int         last_entry;
  logic       m_hv, m_p, m_n;
  logic [1:0] m_st;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] st, input logic r, input logic g, input logic f);
    chk({name, ".state"}, int'(bus.state), int'(st));
    chk({name, ".red"}, int'(bus.red_ctrl), int'(r));
    chk({name, ".green"}, int'(bus.green_ctrl), int'(g));
    chk({name, ".fault"}, int'(bus.fault), int'(f));
  endtask

  task automatic model_reset();
    edge_n     = 0;
    last_entry = 0;
    m_hv = 1'b0; m_p = 1'b0; m_n = 1'b0;
    m_st = S_LAMP;
  endtask

  // Value the debouncer compares at edge e: the raw input two edges earlier (0 before reset release).
  function automatic logic samp(input int which, input int e);
    int idx = e - 2;
    if (idx < 1) return 1'b0;
    case (which)
      0:       return raw_hv[idx];
      1:       return raw_p[idx];
      default: return raw_n[idx];
    endcase
  endfunction

  // Debounced value flips once the last DB samples all disagree with it.
  function automatic logic db_after(input logic cur, input int which, input int c);
    for (int k = 0; k < DB; k++)
      if (samp(which, c - k) == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_edge(input logic hv, input logic p, input logic n, input logic clr);
    int         c;
    logic       imp;
    logic       hold;
    logic [1:0] nx;
    exp_t       e;
    if (edge_n >= MAXC - 2) begin
      $display("FAIL model_capacity: got %0d edges, expected fewer than %0d", edge_n, MAXC);
      $fatal(1);
    end
    edge_n++;
    c = edge_n;
    raw_hv[c] = hv; raw_p[c] = p; raw_n[c] = n;
    imp = (m_hv && !m_p && !m_n) || (!m_hv && m_p && m_n);
    imp_h[c] = imp;
    // Fault threshold: implausible at each of the previous IMPL edges, all after the last FAULT entry.
    hold = (c - IMPL >= 1) && (c - IMPL > last_entry);
    for (int k = c - IMPL; k < c; k++)
      if (k >= 1 && !imp_h[k]) hold = 1'b0;
    nx = m_st;
    case (m_st)
      S_LAMP:   if (c == TEST + 1) nx = S_SAFE;
      S_SAFE:   if (hold) nx = S_FAULT; else if (m_hv && (m_p || m_n)) nx = S_ACTIVE;
      S_ACTIVE: if (hold) nx = S_FAULT; else if (!m_hv && !m_p && !m_n) nx = S_SAFE;
      default:  if (clr && !imp && !m_hv && !hold) nx = S_SAFE;
    endcase
    if (nx == S_FAULT && m_st != S_FAULT) last_entry = c;
    e.st    = nx;
    e.red   = (nx == S_LAMP) || (nx == S_ACTIVE);
    e.green = (nx == S_LAMP) || (nx == S_SAFE);
    e.flt   = (nx == S_FAULT);
    exp_q.push_back(e);
    m_st = nx;
    m_hv = db_after(m_hv, 0, c);
    m_p  = db_after(m_p, 1, c);
    m_n  = db_after(m_n, 2, c);
  endtask

  task automatic cyc(input logic hv, input logic p, input logic n, input logic clr);
    bus.hv_present   = hv;
    bus.air_p_closed = p;
    bus.air_n_closed = n;
    bus.fault_clr    = clr;
    model_edge(hv, p, n, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int len, input logic hv, input logic p, input logic n, input logic clr);
    repeat (len) cyc(hv, p, n, clr);
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk_out("async_reset", S_LAMP, 1'b0, 1'b0, 1'b0);
    repeat (hold_cycles) @(posedge clk);
    #1;
    chk_out("held_reset", S_LAMP, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: the DUT presents a new output set on every edge; compare it half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if ({bus.state, bus.red_ctrl, bus.green_ctrl, bus.fault} != e) begin
          errors++;
          $display("FAIL scoreboard: got state=%0d red=%b green=%b fault=%b, expected state=%0d red=%b green=%b fault=%b at %0t",
                   bus.state, bus.red_ctrl, bus.green_ctrl, bus.fault, e.st, e.red, e.green, e.flt, $time);
        end
      end
    end
  end

  initial begin
    bus.hv_present   = 1'b0;
    bus.air_p_closed = 1'b0;
    bus.air_n_closed = 1'b0;
    bus.fault_clr    = 1'b0;
    model_reset();
    #2;
    chk_out("power_on_reset", S_LAMP, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Lamp test lasts exactly TEST cycles.
    run(TEST, 0, 0, 0, 0);
    chk_out("lamp_test_end", S_LAMP, 1'b1, 1'b1, 1'b0);
    run(1, 0, 0, 0, 0);
    chk_out("enter_safe", S_SAFE, 1'b0, 1'b1, 1'b0);

    // HV with AIR+ closed: ACTIVE exactly DB+3 edges after the input change.
    run(DB + 2, 1, 1, 0, 0);
    chk_out("active_minus1", S_SAFE, 1'b0, 1'b1, 1'b0);
    run(1, 1, 1, 0, 0);
    chk_out("active", S_ACTIVE, 1'b1, 1'b0, 1'b0);
    run(12, 0, 0, 0, 0);
    chk_out("back_safe", S_SAFE, 1'b0, 1'b1, 1'b0);

    // Short HV glitch is filtered.
    run(3, 1, 0, 0, 0);
    run(10, 0, 0, 0, 0);
    chk_out("glitch", S_SAFE, 1'b0, 1'b1, 1'b0);

    // Two implausible bursts shorter than IMPL with a gap do not accumulate.
    run(15, 1, 0, 0, 0);
    run(10, 0, 0, 0, 0);
    run(15, 1, 0, 0, 0);
    run(10, 0, 0, 0, 0);
    chk_out("impl_bursts", S_SAFE, 1'b0, 1'b1, 1'b0);

    // Sustained implausibility latches the fault; clear only when HV is gone.
    run(30, 1, 0, 0, 0);
    chk_out("fault_latch", S_FAULT, 1'b0, 1'b0, 1'b1);
    run(5, 1, 0, 0, 1);
    chk_out("clr_ignored", S_FAULT, 1'b0, 1'b0, 1'b1);
    run(10, 0, 0, 0, 0);
    chk_out("no_pending_clr", S_FAULT, 1'b0, 1'b0, 1'b1);
    run(1, 0, 0, 0, 1);
    chk_out("fault_cleared", S_SAFE, 1'b0, 1'b1, 1'b0);

    // Randomized input segments against the model.
    for (int s = 0; s < 60; s++) begin
      logic rhv, rp, rn, rclr;
      rhv  = 1'($urandom_range(0, 1));
      rp   = 1'($urandom_range(0, 1));
      rn   = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 5) == 0);
      run($urandom_range(1, 28), rhv, rp, rn, rclr);
    end

    // Reset taken while faulted clears everything and restarts the lamp test.
    run(40, 1, 0, 0, 0);
    chk_out("pre_reset_fault", S_FAULT, 1'b0, 1'b0, 1'b1);
    do_reset(3);
    run(5, 0, 0, 0, 0);
    chk_out("lamp_restart", S_LAMP, 1'b1, 1'b1, 1'b0);
    run(TEST - 5 + 1, 0, 0, 0, 0);
    chk_out("safe_after_restart", S_SAFE, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tsal_controller.md
TSAL_CONTROLLER -- requirements
Module: tsal_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4000: consecutive stable cycles required before a debounced input changes.
REQ-002 Parameter IMPL_CYCLES, default 400000: consecutive implausible cycles required before a fault latches.
REQ-003 Parameter TEST_CYCLES, default 4000000: lamp-test duration after reset.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low.
REQ-006 hv_present  input  1  async comparator: 1 = tractive-system voltage above 60 V.
REQ-007 air_p_closed  input  1  async AIR+ auxiliary contact: 1 = closed.
REQ-008 air_n_closed  input  1  async AIR- auxiliary contact: 1 = closed.
REQ-009 fault_clr  input  1  synchronous fault-clear request, level sampled each cycle.
REQ-010 red_ctrl  output  1  drives the downstream red-flash pulse generator; 1 = system active.
REQ-011 green_ctrl  output  1  drives the downstream green lamp; 1 = system safe.
REQ-012 fault  output  1  1 = latched implausibility fault.
REQ-013 state  output  2  current state encoding: LAMP_TEST=0, SAFE=1, ACTIVE=2, FAULT=3.

Function
REQ-014 Each of hv_present, air_p_closed and air_n_closed SHALL pass a 2-FF synchronizer, then a debouncer, producing hv_db, airp_db and airn_db.
REQ-015 Debouncer: the output takes the synchronized value after it has differed from the output for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count from 0.
REQ-016 Implausible SHALL be (hv_db & ~airp_db & ~airn_db) | (~hv_db & airp_db & airn_db).
REQ-017 The implausibility counter increments while implausible, clears to 0 the cycle it deasserts, and saturates at IMPL_CYCLES; impl_hold = (count == IMPL_CYCLES).
REQ-018 LAMP_TEST: red_ctrl=1, green_ctrl=1; after TEST_CYCLES cycles -> SAFE; impl_hold is ignored.
REQ-019 SAFE: green_ctrl=1, red_ctrl=0; impl_hold -> FAULT; otherwise hv_db & (airp_db | airn_db) -> ACTIVE.
REQ-020 ACTIVE: red_ctrl=1, green_ctrl=0; impl_hold -> FAULT; otherwise ~hv_db & ~airp_db & ~airn_db -> SAFE.
REQ-021 FAULT: red_ctrl=0, green_ctrl=0, fault=1; -> SAFE only when fault_clr=1 & ~implausible & ~hv_db; FAULT entry clears the implausibility counter.
REQ-022 Priority: impl_hold over any normal transition; a fault_clr while implausible or hv_db=1 is ignored, with no pending memory.
REQ-023 Outputs are registered and decoded from next-state: they reflect a transition on the same edge that updates state.
REQ-024 Latency: input edge -> debounced change = DEBOUNCE_CYCLES+2 cycles; debounced change -> state/output change = 1 cycle.
REQ-025 No state other than the four listed; any illegal encoding SHALL transition to FAULT.

Reset
REQ-026 rst=0 asynchronously sets: state=LAMP_TEST, red_ctrl=0, green_ctrl=0, fault=0, all counters 0, synchronizers and debounced outputs 0.
REQ-027 The first rising edge after rst deasserts sets red_ctrl=1 and green_ctrl=1; the lamp-test count starts on that edge.
REQ-028 Reset asserted in any state, including mid-debounce or mid-fault, SHALL immediately clear all outputs and the fault latch.

Structure
REQ-029 Package tsal_pkg SHALL hold the state enum and the default values of the three parameters.
REQ-030 Sub-module tsal_debounce (synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-031 Counter widths SHALL be $clog2(parameter+1).

Verification (DEBOUNCE_CYCLES=4, IMPL_CYCLES=20, TEST_CYCLES=10)
REQ-032 Reset release, inputs 0 -> both ctrl=1 for 10 cycles, then state=SAFE, green_ctrl=1.
REQ-033 In SAFE, hv_present=1 and air_p_closed=1 -> ACTIVE 7 cycles after the edge, red_ctrl=1, green_ctrl=0; release both -> SAFE.
REQ-034 A 3-cycle hv_present glitch in SAFE -> no debounced change; state stays SAFE.
REQ-035 hv_present=1 with both AIRs open for 30 cycles -> FAULT when the count reaches 20; fault_clr while hv=1 ignored; hv=0 then fault_clr=1 -> SAFE.
REQ-036 Implausibility held 15 cycles, dropped, then held 15 again -> no fault.
REQ-037 rst=0 during FAULT -> fault=0 and ctrl=0 asynchronously; lamp test restarts after release.
